// File: rtl/sum_engine.sv
// Sequential word summer: reads NUM_WORDS memory words, one per cycle, and
// accumulates them. It reports the running sum and the cycles elapsed.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | issuing reads at addresses 0..NUM_WORDS-1, one per cycle
// DRAIN | no read issued; waiting for the last read data to be added
// DONE  | final sum/cycle held; start restarts the run
module sum_engine #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int NUM_WORDS = 256,
   parameter int SUM_W     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [SUM_W-1:0]  sum,
   output logic [SUM_W-1:0]  cycle,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   state_t state, state_nxt;
   logic   rd_vld;
   logic   accept;
   logic   last;

   assign last  = (rd_addr == LAST_ADDR);
   assign rd_en = (state == RUN);
   assign busy  = (state == RUN) || (state == DRAIN);
   assign done  = (state == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN:     if (last) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // rd_addr stops at the last address instead of wrapping, so it holds
   // NUM_WORDS-1 through DRAIN and DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_addr <= '0;
         rd_vld  <= 1'b0;
         sum     <= '0;
         cycle   <= '0;
      end else begin
         rd_vld <= rd_en;
         if (accept) begin
            rd_addr <= '0;
            sum     <= '0;
            cycle   <= '0;
         end else begin
            if (rd_en && !last) rd_addr <= rd_addr + ADDR_W'(1);
            if (busy)           cycle   <= cycle + SUM_W'(1);
            if (rd_vld)         sum     <= sum + SUM_W'(rd_data);
         end
      end
   end

endmodule

// File: tb/tb_sum_engine.sv
// Randomized bench for sum_engine: word memory model, address monitor and
// arithmetic reference sums; a second small instance exercises sum wrap.
module tb_sum_engine;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int N  = 256;
   localparam int SW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [SW-1:0] sum;
   logic [SW-1:0] cycle;
   logic          busy;
   logic          done;

   logic          start2;
   logic          rd_en2;
   logic [1:0]    rd_addr2;
   logic [15:0]   rd_data2;
   logic [15:0]   sum2;
   logic [15:0]   cycle2;
   logic          busy2;
   logic          done2;

   logic [DW-1:0] mem [N];

   int vectors     = 0;
   int miscompares = 0;

   sum_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .SUM_W(SW)) dut (
      .clock(clock), .reset(reset), .start(start), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .sum(sum), .cycle(cycle),
      .busy(busy), .done(done)
   );

   sum_engine #(.ADDR_W(2), .DATA_W(16), .NUM_WORDS(4), .SUM_W(16)) dut_small (
      .clock(clock), .reset(reset), .start(start2), .rd_en(rd_en2),
      .rd_addr(rd_addr2), .rd_data(rd_data2), .sum(sum2), .cycle(cycle2),
      .busy(busy2), .done(done2)
   );

   always #5 clock = ~clock;

   // Synchronous-read memories; garbage is returned when no read is issued.
   always @(posedge clock) begin
      rd_data  <= rd_en  ? mem[rd_addr] : DW'($urandom);
      rd_data2 <= rd_en2 ? 16'hFFFF     : 16'($urandom);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Address monitor: reads start at 0 and step by one per cycle; the
   // address holds whenever no read is issued.
   logic          mon_prev_en   = 1'b0;
   logic [AW-1:0] mon_prev_addr = '0;
   logic          mon_prev_rst  = 1'b1;
   int            rd_count      = 0;

   always @(posedge clock) begin
      #2;
      if (reset) begin
         mon_prev_rst = 1'b1;
         mon_prev_en  = 1'b0;
         rd_count     = 0;
      end else begin
         if (rd_en) begin
            check("rd_addr_step", 64'(rd_addr), mon_prev_en ? 64'(mon_prev_addr) + 64'd1 : 64'd0);
            if (!mon_prev_en) rd_count = 0;
            rd_count++;
         end else if (!mon_prev_rst) begin
            check("rd_addr_hold", 64'(rd_addr), 64'(mon_prev_addr));
         end
         mon_prev_en   = rd_en;
         mon_prev_addr = rd_addr;
         mon_prev_rst  = 1'b0;
      end
   end

   function automatic logic [SW-1:0] model_sum();
      logic [SW-1:0] s = '0;
      for (int i = 0; i < N; i++) s += SW'(mem[i]);
      return s;
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < N; i++) mem[i] = DW'(i);
   endtask

   // One start pulse; optionally a second start pulse poke_at edges in.
   task automatic run_pulse(input string tag, input logic [SW-1:0] exp_sum, input int poke_at);
      int edges;
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      check({tag, "_done_start"}, 64'(done), 64'd0);
      while (!done && edges < N + 20) begin
         start = (edges == poke_at);
         tick();
         edges++;
      end
      start = 1'b0;
      check({tag, "_done_edges"}, 64'(edges), 64'(N + 2));
      check({tag, "_sum"},   64'(sum),   64'(exp_sum));
      check({tag, "_cycle"}, 64'(cycle), 64'(N + 1));
      check({tag, "_busy"},  64'(busy),  64'd0);
      check({tag, "_done"},  64'(done),  64'd1);
      check({tag, "_reads"}, 64'(rd_count), 64'(N));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_sum"},     64'(sum),     64'd0);
      check({tag, "_cycle"},   64'(cycle),   64'd0);
      check({tag, "_rd_en"},   64'(rd_en),   64'd0);
      check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      check({tag, "_busy"},    64'(busy),    64'd0);
      check({tag, "_done"},    64'(done),    64'd0);
   endtask

   initial begin
      int edges;
      logic [SW-1:0] exp_s;

      reset  = 1'b1;
      start  = 1'b0;
      start2 = 1'b0;
      for (int i = 0; i < N; i++) mem[i] = '1;
      #1;
      check_cleared("reset");
      check("reset_small_sum",  64'(sum2),  64'd0);
      check("reset_small_done", 64'(done2), 64'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      check_cleared("idle");

      // All 0xFFFF
      run_pulse("all_ffff", 32'h00FFFF00, -1);

      // Word = address
      fill_ramp();
      run_pulse("ramp", 32'h00007F80, -1);

      repeat (5) tick();
      check("hold_done",  64'(done),  64'd1);
      check("hold_sum",   64'(sum),   64'h7F80);
      check("hold_cycle", 64'(cycle), 64'(N + 1));
      check("hold_rd_en", 64'(rd_en), 64'd0);

      // Start while busy is ignored
      run_pulse("ignored_start", 32'h00007F80, 50);

      // Random memory contents
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
         mem[$urandom_range(0, N - 1)] = '1;
         exp_s = model_sum();
         run_pulse($sformatf("rand%0d", r), exp_s, -1);
      end

      // Reset mid-run, then a fresh run
      fill_ramp();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (99) tick();
      check("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      check_cleared("mid_reset");
      repeat (3) tick();
      check_cleared("mid_reset_held");
      reset = 1'b0;
      repeat (3) tick();
      check_cleared("post_reset");
      run_pulse("after_reset", 32'h00007F80, -1);

      // Start held high: back-to-back runs
      start = 1'b1;
      edges = 0;
      while (!done && edges < 2 * N) begin
         tick();
         edges++;
      end
      for (int r = 0; r < 3; r++) begin
         check($sformatf("held%0d_done", r),  64'(done),  64'd1);
         check($sformatf("held%0d_sum", r),   64'(sum),   64'h7F80);
         check($sformatf("held%0d_cycle", r), 64'(cycle), 64'(N + 1));
         tick();
         check($sformatf("held%0d_done_1cyc", r), 64'(done), 64'd0);
         check($sformatf("held%0d_restart", r),   64'(busy), 64'd1);
         edges = 1;
         while (!done && edges < N + 20) begin
            tick();
            edges++;
         end
         check($sformatf("held%0d_period", r), 64'(edges), 64'(N + 2));
      end
      start = 1'b0;

      // Small instance: 4 x 0xFFFF in 16 bits wraps
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      edges = 1;
      while (!done2 && edges < 20) begin
         tick();
         edges++;
      end
      check("small_edges", 64'(edges),  64'd6);
      check("small_sum",   64'(sum2),   64'hFFFC);
      check("small_cycle", 64'(cycle2), 64'd5);
      check("small_busy",  64'(busy2),  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sum_engine.md
SUM_ENGINE -- requirements
Module: sum_engine

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: width of the word-memory address.
REQ-002 The block SHALL have parameter DATA_W, default 16: width of one memory word.
REQ-003 The block SHALL have parameter NUM_WORDS, default 256: words summed per run, with 2 <= NUM_WORDS <= 2^ADDR_W.
REQ-004 The block SHALL have parameter SUM_W, default 32: width of the sum and cycle outputs.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: run request, sampled on each rising edge.
REQ-008 The block SHALL have port rd_en, output, 1 bit: memory read strobe.
REQ-009 The block SHALL have port rd_addr, output, ADDR_W bits: memory read address.
REQ-010 The block SHALL have port rd_data, input, DATA_W bits: memory read data, valid exactly one cycle after the rd_en cycle.
REQ-011 The block SHALL have port sum, output, SUM_W bits: running and final sum.
REQ-012 The block SHALL have port cycle, output, SUM_W bits: cycles elapsed in the current or last run.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: level, high from run completion until the next start or reset.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL, on the next edge: clear sum, cycle and rd_addr to 0, clear done, and enter RUN.
REQ-017 In RUN, rd_en SHALL be 1 and rd_addr SHALL step by 1 per cycle, covering 0..NUM_WORDS-1 with exactly one cycle per address.
REQ-018 RUN SHALL be followed by DRAIN after the cycle that issues address NUM_WORDS-1.
REQ-019 In DRAIN, rd_en SHALL be 0 and the FSM SHALL enter DONE after one cycle.
REQ-020 A one-cycle registered valid SHALL track rd_en, and sum SHALL add zero-extended rd_data when that valid is set.
REQ-021 Sum arithmetic SHALL be modulo 2^SUM_W, wrapping silently.
REQ-022 Cycle SHALL increment by 1 on every edge spent in RUN or DRAIN and SHALL wrap modulo 2^SUM_W.
REQ-023 Final values SHALL be: cycle = NUM_WORDS+1; done rises NUM_WORDS+2 edges after the start edge.
REQ-024 Busy SHALL be 1 exactly in RUN and DRAIN.
REQ-025 Done SHALL be 1 exactly in DONE.
REQ-026 Outside RUN, rd_en SHALL be 0 and rd_addr SHALL hold its value.
REQ-027 Start while busy SHALL be ignored, with no restart and no effect on sum or cycle.
REQ-028 Start held high continuously SHALL cause an immediate restart on the first edge in DONE.
REQ-029 sum and cycle SHALL hold their final values in DONE until the next accepted start.

Reset
REQ-030 While reset=1, regardless of clock, the block SHALL be in IDLE with rd_en=0, rd_addr=0, sum=0, cycle=0, busy=0, done=0, and the read-valid register cleared.
REQ-031 Reset asserted mid-run SHALL abort the run; any read data returned after reset SHALL NOT be accumulated.
REQ-032 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-033 Default parameters, memory all 0xFFFF, one start pulse: after 258 edges, done=1, sum=0x00FFFF00, cycle=0x00000101, busy=0.
REQ-034 Default parameters, memory word = address: sum=0x00007F80, and rd_addr must be observed 0..255 in consecutive cycles.
REQ-035 Start pulsed again 50 cycles into a run: must complete on the original schedule with sum unchanged versus REQ-034.
REQ-036 Reset asserted for 3 cycles at cycle 100 of a run: outputs must be 0 immediately; a fresh start must then produce sum=0x00007F80.
REQ-037 SUM_W=16, NUM_WORDS=4, all words 0xFFFF: sum must wrap to 0xFFFC, with cycle=5.
REQ-038 Start held high: done must be high for exactly one cycle between runs, and every run must report identical sum and cycle.
